pipe_run_monitor: RTL and testbench

- Parametrised successor to the fixed-reset pipeline bench harness. It sequences core reset release, counts cycles, retirements and branch outcomes, detects halt or timeout, and produces a sticky pass/fail verdict.
- Instantiated beside the pipeline in benches and FPGA bring-up tops. Drives the core's reset; observes its retire port.
- Supports restart without global reset.

---
 rtl/pipe_mon_pkg.sv | 24 ++
 rtl/pipe_run_monitor_sat_counter.sv | 50 +++++
 rtl/pipe_run_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_run_monitor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mon_pkg
// Purpose  : Shared types and constants for the pipeline run monitor.
//            mon_state_e  - monitor FSM state encoding (2 bits).
//            c_CNT_ONES   - all-ones source for saturating counters; a
//                           counter of width W uses c_CNT_ONES[W-1:0]
//                           (valid for W <= c_MAX_CNT_W).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_mon_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  localparam int unsigned             c_MAX_CNT_W = 64;
  localparam logic [c_MAX_CNT_W-1:0]  c_CNT_ONES  = '1;

endpackage : pipe_mon_pkg
`default_nettype wire

// File: rtl/pipe_run_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
//            Synchronous clear has priority over increment.
// Ports    : clk_i   - clock
//            reset_i - asynchronous active-high reset (count -> 0)
//            clr_i   - synchronous clear
//            inc_i   - increment request
//            q_o     - registered count value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import pipe_mon_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] c_ONES = c_CNT_ONES[W-1:0];

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != c_ONES)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pipe_run_monitor
// Purpose  : Sequences core reset release, counts RUN cycles, retirements and
//            branch outcomes, detects halt or timeout, and produces a sticky
//            pass/fail verdict. Restartable from DONE without global reset.
// Ports    : clk_i, reset_i (async, active-high)
//            restart_i                      - re-run request, DONE only
//            retire_valid_i / retire_pc_i   - retire port of the core
//            retire_is_branch_i, branch_taken_i, branch_mispredict_i
//            halt_i                         - core halted (level, RUN only)
//            core_reset_o                   - reset to the core under test
//            state_o                        - current mon_state_e
//            *_count_o                      - saturating statistics
//            last_pc_o                      - PC of last counted retirement
//            done_o / pass_o / timeout_o    - sticky verdict
// Revision : 1.0 - initial release
// ============================================================================
module pipe_run_monitor
  import pipe_mon_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int CNT_W             = 32,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 1000,
  parameter int DRAIN_CYCLES      = 4,
  parameter int EXPECT_RETIRE     = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             restart_i,
  input  logic             retire_valid_i,
  input  logic [XLEN-1:0]  retire_pc_i,
  input  logic             retire_is_branch_i,
  input  logic             branch_taken_i,
  input  logic             branch_mispredict_i,
  input  logic             halt_i,
  output logic             core_reset_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] retire_count_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] taken_count_o,
  output logic [CNT_W-1:0] mispredict_count_o,
  output logic [XLEN-1:0]  last_pc_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] c_ONES = c_CNT_ONES[CNT_W-1:0];

  mon_state_e       state_q, state_d;
  logic [31:0]      hold_cnt_q, hold_cnt_d;
  logic [31:0]      drain_cnt_q, drain_cnt_d;
  logic             core_reset_q, core_reset_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;

  logic             w_active;
  logic             w_retire;
  logic             w_branch;
  logic             w_clr;
  logic             w_timeout_hit;
  logic [CNT_W-1:0] w_retire_next;
  logic             w_expect_ok;

  // Retire port is only observed while the core is running or draining.
  assign w_active = (state_q == RUN) || (state_q == DRAIN);
  assign w_retire = w_active && retire_valid_i;
  assign w_branch = w_retire && retire_is_branch_i;
  assign w_clr    = (state_q == DONE) && restart_i;

  // Compared at 64 bits so a narrow CNT_W cannot alias the limit.
  assign w_timeout_hit = (64'(cycle_count_o) == 64'(TIMEOUT_CYCLES - 1));

  // The verdict is registered on the DONE-entry edge, which may itself carry
  // a retirement, so it is judged against the post-edge retire count.
  assign w_retire_next = (w_retire && (retire_count_o != c_ONES))
                         ? retire_count_o + CNT_W'(1) : retire_count_o;
  assign w_expect_ok   = (EXPECT_RETIRE == 0) ||
                         (64'(w_retire_next) == 64'(EXPECT_RETIRE));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD: begin
        if (hold_cnt_q == 32'(RESET_HOLD_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        // Halt has priority over a coincident timeout.
        if (halt_i) begin
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else if (w_timeout_hit) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 32'(DRAIN_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        if (restart_i) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    hold_cnt_d   = ((state_q == HOLD) && (state_d == HOLD))   ? hold_cnt_q + 32'd1  : 32'd0;
    drain_cnt_d  = ((state_q == DRAIN) && (state_d == DRAIN)) ? drain_cnt_q + 32'd1 : 32'd0;
    core_reset_d = (state_d == HOLD);
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    last_pc_d    = last_pc_q;

    if (w_clr) begin
      done_d    = 1'b0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
      last_pc_d = '0;
    end else begin
      if (w_retire) last_pc_d = retire_pc_i;
      if ((state_q != DONE) && (state_d == DONE)) begin
        // Entering DONE straight from RUN without halt means timeout.
        timeout_d = (state_q == RUN) && !halt_i;
        done_d    = 1'b1;
        pass_d    = !timeout_d && w_expect_ok;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_cnt_q   <= 32'd0;
      drain_cnt_q  <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      last_pc_q    <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      last_pc_q    <= last_pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics counters
  // --------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(w_clr),
    .inc_i(state_q == RUN), .q_o(cycle_count_o)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(w_clr),
    .inc_i(w_retire), .q_o(retire_count_o)
  );

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(w_clr),
    .inc_i(w_branch), .q_o(branch_count_o)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(w_clr),
    .inc_i(w_branch && branch_taken_i), .q_o(taken_count_o)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(w_clr),
    .inc_i(w_branch && branch_mispredict_i), .q_o(mispredict_count_o)
  );

  assign core_reset_o = core_reset_q;
  assign state_o      = state_q;
  assign last_pc_o    = last_pc_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign timeout_o    = timeout_q;

endmodule : pipe_run_monitor
`default_nettype wire

// File: tb/tb_pipe_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_run_monitor
// Purpose  : Directed self-checking bench for pipe_run_monitor. Four
//            instances with different parameter sets share the retire-side
//            inputs; each has its own reset so only the instance under test
//            is out of reset at any time.
//              u0 : defaults
//              u1 : TIMEOUT_CYCLES=50
//              u2 : EXPECT_RETIRE=5
//              u3 : CNT_W=4
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_run_monitor;
  import pipe_mon_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [4];
  logic        restart, rv, isb, tkn, mis, halt;
  logic [31:0] pc;

  logic        core_reset [4];
  logic [1:0]  st         [4];
  logic [31:0] lpc        [4];
  logic        done       [4];
  logic        pass       [4];
  logic        tmo        [4];
  logic [31:0] cyc [3];
  logic [31:0] ret [3];
  logic [31:0] br  [3];
  logic [31:0] tk  [3];
  logic [31:0] mp  [3];
  logic [3:0]  s_cyc, s_ret, s_br, s_tk, s_mp;

  int checks   = 0;
  int failures = 0;

  pipe_run_monitor u0 (
    .clk_i(clk), .reset_i(rst[0]), .restart_i(restart), .retire_valid_i(rv),
    .retire_pc_i(pc), .retire_is_branch_i(isb), .branch_taken_i(tkn),
    .branch_mispredict_i(mis), .halt_i(halt), .core_reset_o(core_reset[0]),
    .state_o(st[0]), .cycle_count_o(cyc[0]), .retire_count_o(ret[0]),
    .branch_count_o(br[0]), .taken_count_o(tk[0]), .mispredict_count_o(mp[0]),
    .last_pc_o(lpc[0]), .done_o(done[0]), .pass_o(pass[0]), .timeout_o(tmo[0])
  );

  pipe_run_monitor #(.TIMEOUT_CYCLES(50)) u1 (
    .clk_i(clk), .reset_i(rst[1]), .restart_i(restart), .retire_valid_i(rv),
    .retire_pc_i(pc), .retire_is_branch_i(isb), .branch_taken_i(tkn),
    .branch_mispredict_i(mis), .halt_i(halt), .core_reset_o(core_reset[1]),
    .state_o(st[1]), .cycle_count_o(cyc[1]), .retire_count_o(ret[1]),
    .branch_count_o(br[1]), .taken_count_o(tk[1]), .mispredict_count_o(mp[1]),
    .last_pc_o(lpc[1]), .done_o(done[1]), .pass_o(pass[1]), .timeout_o(tmo[1])
  );

  pipe_run_monitor #(.EXPECT_RETIRE(5)) u2 (
    .clk_i(clk), .reset_i(rst[2]), .restart_i(restart), .retire_valid_i(rv),
    .retire_pc_i(pc), .retire_is_branch_i(isb), .branch_taken_i(tkn),
    .branch_mispredict_i(mis), .halt_i(halt), .core_reset_o(core_reset[2]),
    .state_o(st[2]), .cycle_count_o(cyc[2]), .retire_count_o(ret[2]),
    .branch_count_o(br[2]), .taken_count_o(tk[2]), .mispredict_count_o(mp[2]),
    .last_pc_o(lpc[2]), .done_o(done[2]), .pass_o(pass[2]), .timeout_o(tmo[2])
  );

  pipe_run_monitor #(.CNT_W(4)) u3 (
    .clk_i(clk), .reset_i(rst[3]), .restart_i(restart), .retire_valid_i(rv),
    .retire_pc_i(pc), .retire_is_branch_i(isb), .branch_taken_i(tkn),
    .branch_mispredict_i(mis), .halt_i(halt), .core_reset_o(core_reset[3]),
    .state_o(st[3]), .cycle_count_o(s_cyc), .retire_count_o(s_ret),
    .branch_count_o(s_br), .taken_count_o(s_tk), .mispredict_count_o(s_mp),
    .last_pc_o(lpc[3]), .done_o(done[3]), .pass_o(pass[3]), .timeout_o(tmo[3])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = '{1'b1, 1'b1, 1'b1, 1'b1};
    restart = 1'b0; rv = 1'b0; isb = 1'b0; tkn = 1'b0; mis = 1'b0; halt = 1'b0;
    pc      = 32'h0;

    // ---------------- u0: reset values, hold sequencing ----------------
    #1;
    chk("rst_state",      st[0],         HOLD);
    chk("rst_core_reset", core_reset[0], 1);
    chk("rst_retire",     ret[0],        0);
    chk("rst_cycle",      cyc[0],        0);
    chk("rst_done",       done[0],       0);
    #19;
    rst[0] = 1'b0;                    // released at t=20
    tick();
    chk("hold_e1_core_reset", core_reset[0], 1);
    chk("hold_e1_state",      st[0],         HOLD);
    tick();
    chk("hold_e2_core_reset", core_reset[0], 0);
    chk("hold_e2_state",      st[0],         RUN);
    chk("run_start_cycle",    cyc[0],        0);

    // ---------------- u0: main run ----------------
    // Branches at i=2 (taken), 5 (taken), 7 (mispredict). taken at i=3 and
    // mispredict at i=4 arrive without is_branch and must be ignored.
    for (int i = 0; i < 10; i++) begin
      rv  = 1'b1;
      pc  = 32'h100 + 32'(4 * i);
      isb = (i == 2) || (i == 5) || (i == 7);
      tkn = (i == 2) || (i == 5) || (i == 3);
      mis = (i == 7) || (i == 4);
      tick();
    end
    chk("run_retire",  ret[0], 10);
    chk("run_branch",  br[0],  3);
    chk("run_taken",   tk[0],  2);
    chk("run_mispred", mp[0],  1);
    chk("run_lastpc",  lpc[0], 32'h124);
    chk("run_cycle",   cyc[0], 10);
    rv = 1'b0; isb = 1'b0; tkn = 1'b0; mis = 1'b0; halt = 1'b1;
    tick();
    chk("halt_state", st[0],  DRAIN);
    chk("halt_cycle", cyc[0], 11);
    rv = 1'b1; pc = 32'h200;
    tick();
    pc = 32'h204;
    tick();
    rv = 1'b0;
    tick();
    chk("drain3_state", st[0],   DRAIN);
    chk("drain3_done",  done[0], 0);
    tick();
    chk("done_state",   st[0],         DONE);
    chk("done_done",    done[0],       1);
    chk("done_pass",    pass[0],       1);
    chk("done_timeout", tmo[0],        0);
    chk("done_retire",  ret[0],        12);
    chk("done_branch",  br[0],         3);
    chk("done_taken",   tk[0],         2);
    chk("done_mispred", mp[0],         1);
    chk("done_cycle",   cyc[0],        11);
    chk("done_lastpc",  lpc[0],        32'h204);
    chk("done_core_rst", core_reset[0], 0);
    halt = 1'b0; rv = 1'b1; pc = 32'h300;
    tick();
    chk("done_frozen_retire", ret[0], 12);
    chk("done_frozen_lastpc", lpc[0], 32'h204);
    rv = 1'b0;

    // ---------------- u0: restart, then reset mid-DRAIN ----------------
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_state",      st[0],         HOLD);
    chk("rs_core_reset", core_reset[0], 1);
    chk("rs_retire",     ret[0],        0);
    chk("rs_cycle",      cyc[0],        0);
    chk("rs_lastpc",     lpc[0],        0);
    chk("rs_done",       done[0],       0);
    chk("rs_pass",       pass[0],       0);
    tick();
    chk("rs_hold_core_reset", core_reset[0], 1);
    tick();
    chk("rs_run_core_reset", core_reset[0], 0);
    chk("rs_run_state",      st[0],         RUN);
    rv = 1'b1; pc = 32'h400; isb = 1'b1;
    tick();
    isb = 1'b0; pc = 32'h404;
    tick();
    pc = 32'h408;
    tick();
    rv = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("rs_drain_state",  st[0],  DRAIN);
    chk("rs_drain_retire", ret[0], 3);
    chk("rs_drain_branch", br[0],  1);
    rv = 1'b1; pc = 32'h40c;
    tick();
    chk("rs_drain_retire2", ret[0], 4);
    #3;
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_state",      st[0],         HOLD);
    chk("mid_rst_core_reset", core_reset[0], 1);
    chk("mid_rst_retire",     ret[0],        0);
    chk("mid_rst_branch",     br[0],         0);
    chk("mid_rst_cycle",      cyc[0],        0);
    chk("mid_rst_lastpc",     lpc[0],        0);
    chk("mid_rst_done",       done[0],       0);
    rv = 1'b0;

    // ---------------- u1: timeout at 50, then halt on cycle 50 ----------------
    rst[1] = 1'b0;
    tick();
    tick();
    chk("to_run_state", st[1], RUN);
    repeat (49) tick();
    chk("to_49_state", st[1],  RUN);
    chk("to_49_cycle", cyc[1], 49);
    tick();
    chk("to_state",   st[1],   DONE);
    chk("to_cycle",   cyc[1],  50);
    chk("to_timeout", tmo[1],  1);
    chk("to_done",    done[1], 1);
    chk("to_pass",    pass[1], 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("to_rs_timeout", tmo[1], 0);
    chk("to_rs_cycle",   cyc[1], 0);
    tick();
    tick();
    repeat (49) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("to_halt_state",   st[1],  DRAIN);
    chk("to_halt_timeout", tmo[1], 0);
    chk("to_halt_cycle",   cyc[1], 50);
    repeat (4) tick();
    chk("to_halt_done_state", st[1],   DONE);
    chk("to_halt_done_tmo",   tmo[1],  0);
    chk("to_halt_done_pass",  pass[1], 1);
    chk("to_halt_done_cycle", cyc[1],  50);
    rst[1] = 1'b1;

    // ---------------- u2: EXPECT_RETIRE=5 ----------------
    rst[2] = 1'b0;
    tick();
    tick();
    rv = 1'b1; pc = 32'h500;
    repeat (4) tick();
    rv = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    repeat (4) tick();
    chk("exp4_state",  st[2],   DONE);
    chk("exp4_retire", ret[2],  4);
    chk("exp4_done",   done[2], 1);
    chk("exp4_pass",   pass[2], 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    tick();
    chk("exp_rs_state", st[2], RUN);
    rv = 1'b1;
    repeat (4) tick();
    rv = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    repeat (3) tick();
    rv = 1'b1; pc = 32'h5f0;   // fifth retirement in the final drain cycle
    tick();
    rv = 1'b0;
    chk("exp5_state",  st[2],   DONE);
    chk("exp5_retire", ret[2],  5);
    chk("exp5_pass",   pass[2], 1);
    chk("exp5_lastpc", lpc[2],  32'h5f0);
    rst[2] = 1'b1;

    // ---------------- u3: CNT_W=4 saturation ----------------
    rst[3] = 1'b0;
    tick();
    tick();
    rv = 1'b1;
    for (int i = 0; i < 15; i++) begin
      pc = 32'(i);
      tick();
    end
    chk("sat15_retire", s_ret, 15);
    for (int i = 15; i < 19; i++) begin
      pc = 32'(i);
      tick();
    end
    halt = 1'b1; pc = 32'h13;      // twentieth retirement in the halt cycle
    tick();
    halt = 1'b0; rv = 1'b0;
    chk("sat20_retire", s_ret, 15);
    chk("sat20_cycle",  s_cyc, 15);
    chk("sat20_state",  st[3], DRAIN);
    chk("sat20_branch", s_br,  0);
    rst[3] = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_run_monitor
`default_nettype wire
